// File: rtl/fp_conv_pkg.sv
// Shared types, FP32 field geometry and rounding helpers for the float/integer
// conversion pipeline.
package fp_conv_pkg;

  typedef enum logic {OP_F2I = 1'b0, OP_I2F = 1'b1} op_e;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_DENORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  localparam int FP_W      = 32;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_SIG_W  = 24;
  localparam int EXP_BIAS  = 127;
  localparam logic [FP_EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  // Saturated result for invalid conversions: the largest positive integer.
  function automatic logic [63:0] default_invalid(input int int_w);
    return (64'd1 << (int_w - 1)) - 64'd1;
  endfunction

  function automatic logic round_inc(input rm_e rm, input logic sign, input logic lsb,
                                     input logic guard, input logic sticky);
    logic inc;
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RZ:   inc = 1'b0;
      RM_RUP:  inc = !sign & (guard | sticky);
      RM_RDN:  inc = sign & (guard | sticky);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fp_int_convert_pipe_lzc.sv
// Leading-zero counter; o_count = W and o_zero = 1 when the input is all zeros.
module lzc #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_count,
  output logic          o_zero
);

  always_comb begin
    // NOTE: every output gets a value before the loop, so no path leaves it unassigned (no latch).
    o_count = CW'(W);
    o_zero  = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) begin
        o_count = CW'(W - 1 - i);
        o_zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_int_convert_pipe.sv
// Three-stage FP32 <-> signed integer converter (cvt.w.s / cvt.s.w) with a
// valid/ready handshake, all four rounding modes and a pass-through tag.
module fp_int_convert_pipe
  import fp_conv_pkg::*;
#(
  parameter int INT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [1:0]       in_rm,
  input  logic [INT_W-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_inexact,
  output logic             out_invalid
);

  localparam int LZ_W = $clog2(INT_W + 1);
  localparam int FB   = FP_SIG_W + 1;  // fraction bits kept while aligning F2I
  localparam int AW   = INT_W + FB;
  localparam logic [63:0]      INV64   = default_invalid(INT_W);
  localparam logic [INT_W-1:0] MAX_POS = INV64[INT_W-1:0];
  localparam logic [INT_W:0]   LIM_POS = {1'b0, MAX_POS};
  localparam logic [INT_W:0]   LIM_NEG = LIM_POS + 1'b1;

  // ---------------- handshake ----------------
  logic r1_v, r2_v, r3_v;
  logic w_s1_adv, w_s2_adv, w_s3_adv, w_accept;

  assign w_s3_adv  = r3_v & out_ready;
  assign w_s2_adv  = r2_v & (!r3_v | w_s3_adv);
  assign w_s1_adv  = r1_v & (!r2_v | w_s2_adv);
  assign in_ready  = !r1_v | w_s1_adv;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r3_v;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r1_v <= 1'b0;
      r2_v <= 1'b0;
      r3_v <= 1'b0;
    end else begin
      r1_v <= w_accept | (r1_v & !w_s1_adv);
      r2_v <= w_s1_adv | (r2_v & !w_s2_adv);
      r3_v <= w_s2_adv | (r3_v & !w_s3_adv);
    end
  end

  // ---------------- S1: unpack and classify ----------------
  logic [FP_W-1:0]      w_fp;
  logic [FP_EXP_W-1:0]  w_f_exp;
  logic [FP_FRAC_W-1:0] w_f_frac;
  logic                 w_sign, w_inv;
  fp_class_e            w_cls;
  logic [INT_W-1:0]     w_i_mag;

  assign w_fp     = FP_W'(in_data);
  assign w_f_exp  = w_fp[FP_W-2 -: FP_EXP_W];
  assign w_f_frac = w_fp[FP_FRAC_W-1:0];
  assign w_i_mag  = in_data[INT_W-1] ? ({INT_W{1'b0}} - in_data) : in_data;

  always_comb begin
    w_sign = 1'b0;
    w_inv  = 1'b0;
    w_cls  = CLS_NORMAL;
    if (op_e'(in_op) == OP_I2F) begin
      w_sign = in_data[INT_W-1];
    end else begin
      w_sign = w_fp[FP_W-1];
      if (w_f_exp == EXP_SPECIAL) begin
        w_cls = (w_f_frac != '0) ? CLS_NAN : CLS_INF;
        w_inv = 1'b1;
      end else if (w_f_exp == '0) begin
        w_cls = (w_f_frac != '0) ? CLS_DENORM : CLS_ZERO;
      end else if (int'(w_f_exp) >= EXP_BIAS + INT_W) begin
        w_inv = 1'b1;  // magnitude >= 2^INT_W cannot fit for either sign
      end
    end
  end

  op_e                  r1_op;
  rm_e                  r1_rm;
  logic [TAG_W-1:0]     r1_tag;
  logic                 r1_sign, r1_inv;
  fp_class_e            r1_cls;
  logic [FP_EXP_W-1:0]  r1_exp;
  logic [FP_FRAC_W-1:0] r1_frac;
  logic [INT_W-1:0]     r1_mag;

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r1_op   <= op_e'(in_op);
      r1_rm   <= rm_e'(in_rm);
      r1_tag  <= in_tag;
      r1_sign <= w_sign;
      r1_inv  <= w_inv;
      r1_cls  <= w_cls;
      r1_exp  <= w_f_exp;
      r1_frac <= w_f_frac;
      r1_mag  <= w_i_mag;
    end
  end

  // ---------------- S2: normalise (I2F) / align (F2I) ----------------
  logic [LZ_W-1:0]       w_lz;
  logic                  w_mag_zero;
  logic [INT_W-1:0]      w_norm;
  logic [INT_W+FB-1:0]   w_i_ext;
  logic [FP_SIG_W-1:0]   w_i_mant;
  logic [FP_EXP_W-1:0]   w_i_exp;
  logic                  w_i_guard, w_i_sticky;

  lzc #(.W(INT_W), .CW(LZ_W)) u_lzc (
    .i_data  (r1_mag),
    .o_count (w_lz),
    .o_zero  (w_mag_zero)
  );

  assign w_norm     = r1_mag << w_lz;
  assign w_i_ext    = {w_norm, {FB{1'b0}}};
  assign w_i_mant   = w_i_ext[INT_W+FB-1 -: FP_SIG_W];
  assign w_i_guard  = w_i_ext[INT_W];
  assign w_i_sticky = |w_i_ext[INT_W-1:0];
  assign w_i_exp    = FP_EXP_W'(EXP_BIAS + INT_W - 1 - int'(w_lz));

  logic [AW-1:0]    w_f_al;
  logic [INT_W-1:0] w_f_int;
  logic             w_f_guard, w_f_sticky;

  always_comb begin
    w_f_al     = '0;
    w_f_int    = '0;
    w_f_guard  = 1'b0;
    w_f_sticky = 1'b0;
    if (r1_cls == CLS_DENORM) begin
      w_f_sticky = 1'b1;
    end else if (r1_cls == CLS_NORMAL && !r1_inv) begin
      // Values below 1/4 never reach the guard position: collapse them into sticky.
      if (r1_exp < FP_EXP_W'(EXP_BIAS - 2)) begin
        w_f_sticky = 1'b1;
      end else begin
        w_f_al     = AW'({1'b1, r1_frac}) << (r1_exp - FP_EXP_W'(EXP_BIAS - 2));
        w_f_int    = w_f_al[AW-1:FB];
        w_f_guard  = w_f_al[FB-1];
        w_f_sticky = |w_f_al[FB-2:0];
      end
    end
  end

  op_e                 r2_op;
  rm_e                 r2_rm;
  logic [TAG_W-1:0]    r2_tag;
  logic                r2_sign, r2_inv, r2_guard, r2_sticky;
  fp_class_e           r2_cls;
  logic [INT_W-1:0]    r2_int;
  logic [FP_SIG_W-1:0] r2_mant;
  logic [FP_EXP_W-1:0] r2_exp;

  always_ff @(posedge clk) begin
    if (w_s1_adv) begin
      r2_op   <= r1_op;
      r2_rm   <= r1_rm;
      r2_tag  <= r1_tag;
      r2_sign <= r1_sign;
      r2_inv  <= r1_inv;
      r2_int  <= w_f_int;
      r2_mant <= w_i_mant;
      r2_exp  <= w_i_exp;
      if (r1_op == OP_I2F) begin
        r2_cls    <= w_mag_zero ? CLS_ZERO : CLS_NORMAL;
        r2_guard  <= w_i_guard;
        r2_sticky <= w_i_sticky;
      end else begin
        r2_cls    <= r1_cls;
        r2_guard  <= w_f_guard;
        r2_sticky <= w_f_sticky;
      end
    end
  end

  // ---------------- S3: round, pack, flags ----------------
  logic [INT_W:0]       w_f_mag;
  logic                 w_f_ovf;
  logic [INT_W-1:0]     w_f_res;
  logic [FP_SIG_W:0]    w_i_rnd;
  logic [FP_EXP_W-1:0]  w_i_exp_r;
  logic [FP_FRAC_W-1:0] w_i_frac;
  logic [FP_W-1:0]      w_i_pack;

  assign w_f_mag   = {1'b0, r2_int}
                   + (INT_W+1)'(round_inc(r2_rm, r2_sign, r2_int[0], r2_guard, r2_sticky));
  assign w_f_ovf   = r2_sign ? (w_f_mag > LIM_NEG) : (w_f_mag > LIM_POS);
  assign w_f_res   = r2_sign ? ({INT_W{1'b0}} - w_f_mag[INT_W-1:0]) : w_f_mag[INT_W-1:0];

  // A carry out of the mantissa only happens from all-ones, leaving 1.0 at the next exponent.
  assign w_i_rnd   = {1'b0, r2_mant}
                   + (FP_SIG_W+1)'(round_inc(r2_rm, r2_sign, r2_mant[0], r2_guard, r2_sticky));
  assign w_i_exp_r = r2_exp + FP_EXP_W'(w_i_rnd[FP_SIG_W]);
  assign w_i_frac  = w_i_rnd[FP_SIG_W] ? w_i_rnd[FP_SIG_W-1:1] : w_i_rnd[FP_FRAC_W-1:0];
  assign w_i_pack  = {r2_sign, w_i_exp_r, w_i_frac};

  logic [INT_W-1:0] w_res;
  logic             w_inx, w_invf;

  always_comb begin
    w_res  = '0;
    w_inx  = 1'b0;
    w_invf = 1'b0;
    if (r2_op == OP_I2F) begin
      if (r2_cls != CLS_ZERO) begin
        w_res = INT_W'(w_i_pack);
        w_inx = r2_guard | r2_sticky;
      end
    end else if (r2_inv || (r2_cls == CLS_NORMAL && w_f_ovf)) begin
      w_res  = MAX_POS;
      w_invf = 1'b1;
    end else if (r2_cls == CLS_NORMAL) begin
      w_res = w_f_res;
      w_inx = r2_guard | r2_sticky;
    end else begin
      w_inx = r2_sticky;
    end
  end

  logic [INT_W-1:0] r3_data;
  logic [TAG_W-1:0] r3_tag;
  logic             r3_inexact, r3_invalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r3_data    <= '0;
      r3_tag     <= '0;
      r3_inexact <= 1'b0;
      r3_invalid <= 1'b0;
    end else if (w_s2_adv) begin
      r3_data    <= w_res;
      r3_tag     <= r2_tag;
      r3_inexact <= w_inx;
      r3_invalid <= w_invf;
    end
  end

  assign out_data    = r3_data;
  assign out_tag     = r3_tag;
  assign out_inexact = r3_inexact;
  assign out_invalid = r3_invalid;

endmodule

// File: tb/tb_fp_int_convert_pipe.sv
// Directed self-checking bench for fp_int_convert_pipe (INT_W=32, TAG_W=5).
module tb_fp_int_convert_pipe;

  localparam logic       F2I = 1'b0, I2F = 1'b1;
  localparam logic [1:0] RNE = 2'd0, RZ = 2'd1, RUP = 2'd2, RDN = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_op;
  logic [1:0]  in_rm;
  logic [31:0] in_data;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_inexact, out_invalid;

  int n_checks = 0;
  int n_fail   = 0;

  fp_int_convert_pipe #(.INT_W(32), .TAG_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rm       (in_rm),
    .in_data     (in_data),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_inexact (out_inexact),
    .out_invalid (out_invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        op;
    logic [1:0]  rm;
    logic [31:0] d;
    logic [31:0] e;
    logic        inx;
    logic        inv;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic op, input logic [1:0] rm, input logic [31:0] d,
                         input logic [31:0] e, input logic inx, input logic inv);
    vec_t v;
    v.op = op; v.rm = rm; v.d = d; v.e = e; v.inx = inx; v.inv = inv;
    vecs.push_back(v);
  endtask

  // One request through an idle pipe; latency counts edges from the accept edge.
  task automatic run_one(input string name, input vec_t v, input logic [4:0] tag);
    int lat;
    in_valid = 1'b1; in_op = v.op; in_rm = v.rm; in_data = v.d; in_tag = tag;
    out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_data"}, 64'(out_data), 64'(v.e));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    check({name, "_flags_inx_inv"}, 64'({out_inexact, out_invalid}), 64'({v.inx, v.inv}));
    @(posedge clk); #1;
  endtask

  task automatic backpressure();
    logic [31:0] bp_exp [6];
    logic [38:0] prev;
    logic        prev_stall;
    logic        acc, xfer;
    int          sent, recv;
    bp_exp = '{32'h3F800000, 32'h40000000, 32'h40400000,
               32'h40800000, 32'h40A00000, 32'h40C00000};
    sent = 0; recv = 0; prev_stall = 1'b0; prev = '0;
    for (int t = 0; t < 40 && recv < 6; t++) begin
      out_ready = (t >= 5);
      in_valid  = (sent < 6);
      in_op     = I2F;
      in_rm     = RZ;
      in_data   = 32'(sent + 1);
      in_tag    = 5'(10 + sent);
      #1;
      if (t == 3) begin
        check("bp_accepted_before_stall", 64'(sent), 64'd3);
        check("bp_in_ready_dropped", 64'(in_ready), 64'd0);
      end
      if (prev_stall)
        check($sformatf("bp_hold_t%0d", t),
              64'({out_data, out_tag, out_inexact, out_invalid}), 64'(prev));
      acc  = in_valid & in_ready;
      xfer = out_valid & out_ready;
      if (xfer) begin
        check($sformatf("bp_data%0d", recv), 64'(out_data), 64'(bp_exp[recv]));
        check($sformatf("bp_tag%0d", recv), 64'(out_tag), 64'(10 + recv));
        recv++;
      end
      prev_stall = out_valid & !out_ready;
      prev       = {out_data, out_tag, out_inexact, out_invalid};
      if (acc) sent++;
      @(posedge clk); #1;
    end
    check("bp_results_received", 64'(recv), 64'd6);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic reset_mid_flight();
    logic stale;
    vec_t v;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = I2F; in_rm = RNE;
      in_data = 32'(i + 7); in_tag = 5'(20 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stale |= out_valid;
      @(posedge clk); #1;
    end
    check("rst_mid_no_stale", 64'(stale), 64'd0);
    v.op = I2F; v.rm = RNE; v.d = 32'd5; v.e = 32'h40A00000; v.inx = 1'b0; v.inv = 1'b0;
    run_one("rst_mid_new", v, 5'd30);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = F2I; in_rm = RNE;
    in_data = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    check("reset_flags", 64'({out_inexact, out_invalid}), 64'd0);

    // I2F
    add_vec(I2F, RNE, 32'h00000001, 32'h3F800000, 1'b0, 1'b0);
    add_vec(I2F, RNE, 32'h80000000, 32'hCF000000, 1'b0, 1'b0);
    add_vec(I2F, RNE, 32'h01000001, 32'h4B800000, 1'b1, 1'b0);
    add_vec(I2F, RUP, 32'h01000001, 32'h4B800001, 1'b1, 1'b0);
    add_vec(I2F, RZ,  32'h01000001, 32'h4B800000, 1'b1, 1'b0);
    add_vec(I2F, RNE, 32'h01000003, 32'h4B800002, 1'b1, 1'b0);
    add_vec(I2F, RNE, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    add_vec(I2F, RNE, 32'hFFFFFFFF, 32'hBF800000, 1'b0, 1'b0);
    add_vec(I2F, RUP, 32'h7FFFFFFF, 32'h4F000000, 1'b1, 1'b0);
    add_vec(I2F, RZ,  32'h7FFFFFFF, 32'h4EFFFFFF, 1'b1, 1'b0);
    // F2I rounding
    add_vec(F2I, RNE, 32'h40200000, 32'h00000002, 1'b1, 1'b0);
    add_vec(F2I, RZ,  32'h40200000, 32'h00000002, 1'b1, 1'b0);
    add_vec(F2I, RUP, 32'h40200000, 32'h00000003, 1'b1, 1'b0);
    add_vec(F2I, RDN, 32'h40200000, 32'h00000002, 1'b1, 1'b0);
    add_vec(F2I, RNE, 32'hC0200000, 32'hFFFFFFFE, 1'b1, 1'b0);
    add_vec(F2I, RDN, 32'hC0200000, 32'hFFFFFFFD, 1'b1, 1'b0);
    add_vec(F2I, RNE, 32'h3FC00000, 32'h00000002, 1'b1, 1'b0);
    add_vec(F2I, RNE, 32'h3F000000, 32'h00000000, 1'b1, 1'b0);
    add_vec(F2I, RUP, 32'h3E800000, 32'h00000001, 1'b1, 1'b0);
    add_vec(F2I, RNE, 32'h3E800000, 32'h00000000, 1'b1, 1'b0);
    add_vec(F2I, RUP, 32'h3D800000, 32'h00000001, 1'b1, 1'b0);
    add_vec(F2I, RDN, 32'hBD800000, 32'hFFFFFFFF, 1'b1, 1'b0);
    add_vec(F2I, RNE, 32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0);
    // F2I specials and range limits
    add_vec(F2I, RNE, 32'h7FC00000, 32'h7FFFFFFF, 1'b0, 1'b1);
    add_vec(F2I, RNE, 32'h7F800000, 32'h7FFFFFFF, 1'b0, 1'b1);
    add_vec(F2I, RNE, 32'h4F000000, 32'h7FFFFFFF, 1'b0, 1'b1);
    add_vec(F2I, RNE, 32'hCF000000, 32'h80000000, 1'b0, 1'b0);
    add_vec(F2I, RNE, 32'hCF000001, 32'h7FFFFFFF, 1'b0, 1'b1);
    add_vec(F2I, RNE, 32'h5F000000, 32'h7FFFFFFF, 1'b0, 1'b1);
    add_vec(F2I, RNE, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    add_vec(F2I, RNE, 32'h80000000, 32'h00000000, 1'b0, 1'b0);

    foreach (vecs[i]) run_one($sformatf("vec%0d", i), vecs[i], 5'(i));

    backpressure();
    repeat (2) @(posedge clk);
    #1;
    reset_mid_flight();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
